// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared raster timing defaults and types for the VGA frame fetcher
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    typedef logic [7:0] pix_idx_t;

    typedef struct packed {
        logic videoOn;
        logic hsync;
        logic vsync;
        logic frame_start;
    } vga_ctrl_t;

endpackage

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - free-running h/v raster counters with active, sync and frame-start decode
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic SYNC_POL = 1'b0,
    parameter int   HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int   VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic            clk,
    input  logic            rst,
    output logic [HW-1:0]   h_cnt,
    output logic [VW-1:0]   v_cnt,
    output logic            line_end,
    output logic            frame_end,
    output vga_ctrl_t       ctrl
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_S = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_E = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_S = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_E = VW'(V_ACTIVE + V_FP + V_SYNC);

    assign line_end  = (h_cnt == H_LAST);
    assign frame_end = line_end && (v_cnt == V_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (line_end) begin
            h_cnt <= '0;
            v_cnt <= frame_end ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Decode is purely from the counter state; the top delays it to match the read path.
    always_comb begin
        ctrl             = '0;
        ctrl.videoOn     = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
        ctrl.hsync       = ((h_cnt >= H_SYNC_S) && (h_cnt < H_SYNC_E)) ? SYNC_POL : ~SYNC_POL;
        ctrl.vsync       = ((v_cnt >= V_SYNC_S) && (v_cnt < V_SYNC_E)) ? SYNC_POL : ~SYNC_POL;
        ctrl.frame_start = (h_cnt == '0) && (v_cnt == '0);
    end

endmodule

// File: rtl/vga_frame_fetcher.sv
// rtl/vga_frame_fetcher.sv - raster timing, upscaled framebuffer fetch and palette-index clamp; VGA_TEST_PATTERN_EN adds colour bars
module vga_frame_fetcher
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE     = DEF_H_ACTIVE,
    parameter int   H_FP         = DEF_H_FP,
    parameter int   H_SYNC       = DEF_H_SYNC,
    parameter int   H_BP         = DEF_H_BP,
    parameter int   V_ACTIVE     = DEF_V_ACTIVE,
    parameter int   V_FP         = DEF_V_FP,
    parameter int   V_SYNC       = DEF_V_SYNC,
    parameter int   V_BP         = DEF_V_BP,
    parameter logic SYNC_POL     = 1'b0,
    parameter int   SCALE_SHIFT  = 1,
    parameter int   FB_ADDR_W    = 17,
    parameter int   MEM_LAT      = 1,
    parameter int   PALETTE_SIZE = 18
) (
    input  logic                 vgaClk,
    input  logic                 rst,
`ifdef VGA_TEST_PATTERN_EN
    input  logic                 test_en,
`endif
    output logic [FB_ADDR_W-1:0] fb_addr,
    input  logic [7:0]           fb_rdata,
    output pix_idx_t             color_index,
    output logic                 videoOn,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 frame_start
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int D     = MEM_LAT + 2;

    localparam logic [FB_ADDR_W-1:0] LINE_STEP = FB_ADDR_W'(H_ACTIVE >> SCALE_SHIFT);
    localparam logic [VW-1:0]        SUB_MASK  = VW'((1 << SCALE_SHIFT) - 1);
    localparam logic [8:0]           PAL_LIMIT = 9'(PALETTE_SIZE);
    localparam vga_ctrl_t            CTRL_IDLE = vga_ctrl_t'({1'b0, ~SYNC_POL, ~SYNC_POL, 1'b0});

    logic [HW-1:0]        h_cnt;
    logic [VW-1:0]        v_cnt;
    logic                 line_end;
    logic                 frame_end;
    vga_ctrl_t            ctrl;
    logic [FB_ADDR_W-1:0] line_base;
    logic                 v_roll;
    vga_ctrl_t            ctrl_pipe [D];
    pix_idx_t             color_next;
    logic                 fb_in_range;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .SYNC_POL (SYNC_POL),
        .HW       (HW),
        .VW       (VW)
    ) u_timing (
        .clk       (vgaClk),
        .rst       (rst),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .line_end  (line_end),
        .frame_end (frame_end),
        .ctrl      (ctrl)
    );

    // Line base tracks (v_cnt >> SCALE_SHIFT) * framebuffer width; it steps after the
    // last replicated display line of each framebuffer row.
    assign v_roll = ((v_cnt & SUB_MASK) == SUB_MASK);

    always_ff @(posedge vgaClk) begin
        if (rst) begin
            line_base <= '0;
        end else if (line_end) begin
            if (frame_end) begin
                line_base <= '0;
            end else if (v_roll) begin
                line_base <= line_base + LINE_STEP;
            end
        end
    end

    always_ff @(posedge vgaClk) begin
        if (rst) begin
            fb_addr <= '0;
        end else if (ctrl.videoOn) begin
            fb_addr <= line_base + FB_ADDR_W'(h_cnt >> SCALE_SHIFT);
        end else begin
            fb_addr <= '0;
        end
    end

    always_ff @(posedge vgaClk) begin
        if (rst) begin
            for (int i = 0; i < D; i++) begin
                ctrl_pipe[i] <= CTRL_IDLE;
            end
        end else begin
            ctrl_pipe[0] <= ctrl;
            for (int i = 1; i < D; i++) begin
                ctrl_pipe[i] <= ctrl_pipe[i-1];
            end
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    // Pattern value and its enable ride alongside the fetch so they land on the same output cycle.
    logic     tp_en_pipe  [MEM_LAT+1];
    pix_idx_t tp_val_pipe [MEM_LAT+1];
    pix_idx_t tp_val;

    assign tp_val = pix_idx_t'(32'(h_cnt >> 6) % PALETTE_SIZE);

    always_ff @(posedge vgaClk) begin
        if (rst) begin
            for (int i = 0; i <= MEM_LAT; i++) begin
                tp_en_pipe[i]  <= 1'b0;
                tp_val_pipe[i] <= '0;
            end
        end else begin
            tp_en_pipe[0]  <= test_en;
            tp_val_pipe[0] <= tp_val;
            for (int i = 1; i <= MEM_LAT; i++) begin
                tp_en_pipe[i]  <= tp_en_pipe[i-1];
                tp_val_pipe[i] <= tp_val_pipe[i-1];
            end
        end
    end
`endif

    assign fb_in_range = ({1'b0, fb_rdata} < PAL_LIMIT);

    // ctrl_pipe[MEM_LAT] is the stage whose pixel matches the fb_rdata arriving now.
    always_comb begin
        color_next = '0;
        if (ctrl_pipe[MEM_LAT].videoOn) begin
`ifdef VGA_TEST_PATTERN_EN
            if (tp_en_pipe[MEM_LAT]) begin
                color_next = tp_val_pipe[MEM_LAT];
            end else if (fb_in_range) begin
                color_next = fb_rdata;
            end
`else
            if (fb_in_range) begin
                color_next = fb_rdata;
            end
`endif
        end
    end

    always_ff @(posedge vgaClk) begin
        if (rst) begin
            color_index <= '0;
        end else begin
            color_index <= color_next;
        end
    end

    assign videoOn     = ctrl_pipe[D-1].videoOn;
    assign hsync       = ctrl_pipe[D-1].hsync;
    assign vsync       = ctrl_pipe[D-1].vsync;
    assign frame_start = ctrl_pipe[D-1].frame_start;

endmodule
